// File: rtl/rxuart.sv
// rxuart: 8-N-1 serial receiver, LSB first, mid-bit sampling from a per-frame
// down-counter. Define RXUART_PARITY_EN for 8-E-1 frames with a parity_err strobe.
module rxuart #(
  parameter int unsigned CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned HALF = CLOCKS_PER_BAUD / 2;
  localparam int unsigned CW   = $clog2(CLOCKS_PER_BAUD);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef RXUART_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd5;
`endif

  logic          s1, rs;
  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic [7:0]    data_n;
  logic          valid_n, busy_n, frame_err_n;
  logic          tick;
`ifdef RXUART_PARITY_EN
  logic          pbad, pbad_n;
  logic          parity_err_n;
`endif

  // Two-flop synchroniser on the asynchronous line
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b1;
      rs <= 1'b1;
    end else begin
      s1 <= in;
      rs <= s1;
    end
  end

  assign tick = (cnt == '0);

  // Next-state, counter, shift register and output computation
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    sh_n        = sh;
    data_n      = data;
    valid_n     = 1'b0;
    busy_n      = busy;
    frame_err_n = 1'b0;
`ifdef RXUART_PARITY_EN
    pbad_n       = pbad;
    parity_err_n = 1'b0;
`endif

    // Bit-timing counter runs in every in-frame state
    if (state != IDLE && state != WAIT_HIGH) begin
      cnt_n = tick ? CW'(CLOCKS_PER_BAUD - 1) : cnt - CW'(1);
    end

    case (state)
      IDLE: begin
        if (!rs) begin
          state_n = START;
          cnt_n   = CW'(HALF - 1);
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (rs) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            state_n = DATA;
            idx_n   = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sh_n  = {rs, sh[7:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef RXUART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef RXUART_PARITY_EN
      PARITY: begin
        if (tick) begin
          pbad_n  = rs ^ (^sh);
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rs) begin
            state_n = IDLE;
            busy_n  = 1'b0;
`ifdef RXUART_PARITY_EN
            if (pbad) begin
              parity_err_n = 1'b1;
            end else begin
              valid_n = 1'b1;
              data_n  = sh;
            end
`else
            valid_n = 1'b1;
            data_n  = sh;
`endif
          end else begin
            state_n     = WAIT_HIGH;
            frame_err_n = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        // A break holds here; only a returning high line re-arms the receiver
        if (rs) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      sh        <= 8'd0;
      data      <= 8'd0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      data      <= data_n;
      valid     <= valid_n;
      busy      <= busy_n;
      frame_err <= frame_err_n;
    end
  end

`ifdef RXUART_PARITY_EN
  // Parity mismatch flag and its strobe
  always_ff @(posedge clk) begin
    if (!reset) begin
      pbad       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      pbad       <= pbad_n;
      parity_err <= parity_err_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rxuart.sv
// tb_rxuart: randomized frames against a queue-based scoreboard for rxuart.
module tb_rxuart;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef RXUART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Line fall (sampled at a negedge) to strobe-visible negedge
  localparam int LAT = 3 + H + (NBITS - 1) * C;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       line = 1'b1;
  logic [7:0] data;
  logic       valid, busy, frame_err, parity_err;

  rxuart #(.CLOCKS_PER_BAUD(C)) dut (
    .clk(clk), .reset(reset), .in(line), .data(data), .valid(valid),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 valid, 1 frame_err, 2 parity_err
    logic [7:0] d;
    int         t;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         vectors = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; abort_bit >= 0 pulses reset in the middle of that bit
  task automatic send(input logic [7:0] b, input bit pflip, input bit stop_ok, input int abort_bit);
    exp_t e;
    logic bits[NBITS];
    bit   pf;
`ifdef RXUART_PARITY_EN
    pf = pflip;
`else
    pf = 1'b0;
`endif
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = b[k];
`ifdef RXUART_PARITY_EN
    bits[9] = (^b) ^ pf;
`endif
    bits[NBITS-1] = stop_ok;
    e.t    = cyc + LAT;
    e.kind = !stop_ok ? 1 : (pf ? 2 : 0);
    e.d    = (e.kind == 0) ? b : last_good;
    if (abort_bit < 0) begin
      sb.push_back(e);
      if (e.kind == 0) last_good = b;
    end
    for (int k = 0; k < NBITS; k++) begin
      line = bits[k];
      if (k == abort_bit) begin
        ticks(H);
        reset = 1'b0;
        line  = 1'b1;
        ticks(1);
        reset = 1'b1;
        chk("abort_data", 32'(data), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_valid", 32'(valid), 32'h0);
        last_good = 8'd0;
        ticks(2 * C);
        return;
      end
      ticks(C);
    end
    if (!stop_ok) begin
      ticks(40);
      line = 1'b1;
      ticks(C);
    end
    line = 1'b1;
  endtask

  // Short low glitch that must be rejected at the start-bit sample
  task automatic false_start();
    line = 1'b0;
    ticks(3);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    ticks(1);
    line = 1'b1;
    ticks(C);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
  endtask

  // Scoreboard monitor: pops one expectation per output strobe
  initial begin
    exp_t e;
    int   kind;
    forever begin
      @(negedge clk);
      if (valid || frame_err || parity_err) begin
        chk("strobe_excl", 32'(int'(valid) + int'(frame_err) + int'(parity_err)), 32'h1);
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b parity_err=%0b at cycle %0d, none expected",
                   valid, frame_err, parity_err, cyc);
        end else begin
          e = sb.pop_front();
          kind = valid ? 0 : (frame_err ? 1 : 2);
          chk("strobe_kind", 32'(kind), 32'(e.kind));
          chk("strobe_time", 32'(cyc), 32'(e.t));
          chk("strobe_data", 32'(data), 32'(e.d));
          if (e.kind != 1) chk("strobe_busy", 32'(busy), 32'h0);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int r;
    int w;
    logic [7:0] b;
    reset = 1'b0;
    line  = 1'b1;
    ticks(3);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    reset = 1'b1;
    ticks(5);

    send(8'h55, 1'b0, 1'b1, -1);
    ticks(C);
    send(8'hA5, 1'b0, 1'b1, -1);
    send(8'h3C, 1'b0, 1'b1, -1);
    ticks(C);
    false_start();
    send(8'h81, 1'b0, 1'b0, -1);
    send(8'h7E, 1'b0, 1'b1, -1);
    ticks(C);
    send(8'hFF, 1'b0, 1'b1, 4);
    send(8'h12, 1'b0, 1'b1, -1);
`ifdef RXUART_PARITY_EN
    send(8'h03, 1'b0, 1'b1, -1);
    send(8'h03, 1'b1, 1'b1, -1);
`endif

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom);
      case (r)
        6:       send(b, 1'b0, 1'b0, -1);
        7:       false_start();
        8:       send(b, 1'b1, 1'($urandom_range(0, 1)), -1);
        9:       send(b, 1'b0, 1'b1, $urandom_range(1, NBITS - 2));
        default: send(b, 1'b0, 1'b1, -1);
      endcase
      ticks($urandom_range(0, 20));
    end

    w = 0;
    while (sb.size() > 0 && w < 500) begin
      ticks(1);
      w++;
    end
    if (sb.size() > 0) begin
      vectors++;
      errors++;
      $display("FAIL missing_strobe: %0d expected strobes never seen", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rxuart.md
# rxuart

Serial UART receiver: the counterpart of the team's `txuart` transmitter. Recovers 8-N-1 frames from an asynchronous serial line, LSB first. Resynchronises the line and samples each bit at mid-bit using a baud counter. Presents each received byte with a one-cycle `valid` strobe. Sits at the pin boundary, feeding byte-oriented logic such as command parsers and loopback test wrappers.

## Interface
- `CLOCKS_PER_BAUD`, 868: clock cycles per bit (100 MHz / 115200 bps); must be ≥ 4.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `in`  in  1  asynchronous serial line; idles high.
- `data`  out  8  last good byte; holds until the next good frame.
- `valid`  out  1  one-cycle strobe; `data` is new this cycle.
- `busy`  out  1  high while a frame is in progress.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `parity_err`  out  1  one-cycle strobe: parity mismatch (macro only; else tied 0).

## Operation
- Two-flop synchroniser on `in`; the second flop output `rs` is used by all logic.
- Definitions: H = CLOCKS_PER_BAUD/2 (integer divide); C = CLOCKS_PER_BAUD.
- Baud counter is a down-counter, reloaded per frame; there is no free-running strobe.
- States: IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY with macro).
- IDLE:
  - `rs`=0 → load counter H-1, enter START, `busy`=1.
- Every state except IDLE and WAIT_HIGH: counter decrements each cycle. At 0: sample `rs`, reload C-1.
- START sample:
  - 1 → false start; go to IDLE, `busy`=0.
  - 0 → go to DATA, bit index = 0.
- DATA: each sample shifts into shift register MSB (right shift), so bit 0 ends up at `data[0]`. After 8th sample → STOP (or PARITY).
- STOP sample:
  - 1 → `data`←shift register, `valid`=1, go to IDLE.
  - 0 → `frame_err`=1, `data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: `busy` stays 1; go to IDLE on the first cycle `rs`=1. No retrigger during a break.
- `valid` and `frame_err` are never asserted together.

## Timing
- Reset values: `data`=0, `valid`=0, `busy`=0, `frame_err`=0, `parity_err`=0, state IDLE, synchroniser flops=1.
- T0 = first IDLE cycle with `rs`=0, two clocks after the `in` fall.
- Sample k occurs in cycle T0+H+k·C:
  - k=0: start bit.
  - k=1..8: data bits.
  - k=9: stop bit (k=10 with parity).
- `valid`/`frame_err` are registered: high for exactly cycle T0+H+9C+1.
- `busy` is high from T0+1 through the stop-sample cycle; it is low in the `valid` cycle.
- Back-to-back frames: the next start edge is accepted from the cycle after the stop sample. Mid-stop-bit sampling gives ½-bit slack.
- Reset low in any cycle:
  - aborts the frame next cycle;
  - no `valid` or error strobe;
  - `data` cleared to 0.

## Configuration
- `RXUART_PARITY_EN` defined:
  - frame is 8-E-1; PARITY state follows DATA and samples the 9th bit;
  - stop bit is sample k=10;
  - `valid`/errors land at T0+H+10C+1.
- Even-parity mismatch with good stop: `parity_err`=1 and `valid`=0, `data` unchanged.
- Parity mismatch with bad stop: `frame_err` only.
- Undefined: 8-N-1 as above; `parity_err` tied 0.

## Test plan
All directed tests use CLOCKS_PER_BAUD=16.
- Frame 0x55 at 16 clocks/bit → `valid` for one cycle at T0+153, `data`=0x55, `frame_err`=0, `busy` low afterwards.
- Back-to-back 0xA5 then 0x3C, zero idle gap → two `valid` strobes 160 cycles apart; `data`=0xA5 then 0x3C.
- `in` low for 4 cycles, then high → `busy` pulses; no `valid` or `frame_err`; back in IDLE at T0+8.
- 0x81 with stop bit forced low, line held low 40 more cycles → `frame_err` one cycle, `data` keeps its previous value. No new frame starts until `in` rises; then 0x7E is received correctly.
- `reset` low at the 4th data bit of 0xFF → outputs take reset values; no `valid`; a following 0x12 is received correctly.
- With `RXUART_PARITY_EN`:
  - 0x03 with parity bit 0 → `valid`, `data`=0x03;
  - 0x03 with parity bit 1 → `parity_err` one cycle, no `valid`.
